// File: rtl/key_reader_pkg.sv
// Shared types and cycle-count helpers for the push-button reader.
// State encoding for the per-key debounce FSM plus ms-to-cycle conversion.
package key_reader_pkg;

    typedef enum logic [2:0] {
        RELEASED,
        DB_PRESS,
        PRESSED,
        HELD,
        DB_RELEASE
    } key_state_t;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

    // Counters only ever reach n-1; keep at least one bit so n=1 stays legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// One key: 2-flop sync, debounce/hold FSM, registered press/release/hold pulses and toggle.
// Latency: pulse visible DB_CYCLES+3 edges after a stable KEY change; no backpressure, pulses are fire-and-forget.
module key_debounce_fsm
    import key_reader_pkg::*;
#(
    parameter int DB_CYCLES      = 4,
    parameter int HOLD_CYCLES    = 20,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic core_clk,
    input  logic arst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_hold,
    output logic key_toggle
);

    localparam int DB_W   = cnt_width(DB_CYCLES);
    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic IDLE_RAW = KEY_ACTIVE_LOW;

    logic [1:0]        sync_q, sync_d;
    key_state_t        state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              held_q, held_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              hold_q, hold_d;
    logic              toggle_q, toggle_d;
    logic              s;

    assign s = sync_q[1] ^ KEY_ACTIVE_LOW;

    always_comb begin
        sync_d     = {sync_q[0], key_raw};
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        held_d     = held_q;
        level_d    = level_q;
        toggle_d   = toggle_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        hold_d     = 1'b0;
        // Counters advance only below their terminal value, so they never wrap.
        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d  = DB_PRESS;
                    db_cnt_d = '0;
                end
            end
            DB_PRESS: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = PRESSED;
                    press_d    = 1'b1;
                    level_d    = 1'b1;
                    toggle_d   = ~toggle_q;
                    hold_cnt_d = '0;
                    held_d     = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d  = DB_RELEASE;
                    db_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = HELD;
                    hold_d  = 1'b1;
                    held_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d  = DB_RELEASE;
                    db_cnt_d = '0;
                end
            end
            DB_RELEASE: begin
                // A release bounce resumes where the press left off; hold_cnt is untouched.
                if (s) begin
                    state_d = held_q ? HELD : PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q     <= {2{IDLE_RAW}};
            state_q    <= RELEASED;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            held_q     <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            hold_q     <= 1'b0;
            toggle_q   <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            held_q     <= held_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            hold_q     <= hold_d;
            toggle_q   <= toggle_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_hold    = hold_q;
    assign key_toggle  = toggle_q;

endmodule

// File: rtl/key_reader.sv
// Board push-button reader: N_KEYS independent synchronise/debounce/hold channels.
// Latency: DB_CYCLES+3 edges from KEY change to press/release pulse; no backpressure.
module key_reader
    import key_reader_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int DEBOUNCE_MS    = 10,
    parameter int HOLD_MS        = 1000,
    parameter int N_KEYS         = 4,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_hold,
    output logic [N_KEYS-1:0] key_toggle
);

    localparam int DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int HOLD_CYCLES = ms_to_cycles(CLK_HZ, HOLD_MS);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce_fsm #(
            .DB_CYCLES      (DB_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_fsm (
            .core_clk    (CLOCK_50),
            .arst_n      (RESET_N),
            .key_raw     (KEY[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_hold    (key_hold[i]),
            .key_toggle  (key_toggle[i])
        );
    end

endmodule

// File: doc/key_reader.md
Name: key_reader

Overview:
- Input-side counterpart to the LED-driving blocks: it reads the DE-board push-buttons instead of writing the LEDs.
- Each of N_KEYS raw, bouncing, asynchronous KEY inputs is synchronised and debounced.
- Per key it produces a clean level, one-cycle press/release/hold pulses, and a press-toggled bit that can drive LEDG/LEDR directly.
- Sits between the board pins and the application logic.

Parameters:
- CLK_HZ, 50000000, clock frequency in Hz.
- DEBOUNCE_MS, 10, stable time required before accepting a level change.
- HOLD_MS, 1000, continuous press time before key_hold fires.
- N_KEYS, 4, number of keys.
- KEY_ACTIVE_LOW, 1, 1 = raw KEY reads 0 when pressed (DE-board buttons).

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  reset, asynchronous, active-low.
- KEY  in  N_KEYS  raw button pins, asynchronous to CLOCK_50.
- key_level  out  N_KEYS  debounced state, 1 = pressed.
- key_press  out  N_KEYS  1-cycle pulse on accepted press.
- key_release  out  N_KEYS  1-cycle pulse on accepted release.
- key_hold  out  N_KEYS  1-cycle pulse when a press lasts HOLD_MS.
- key_toggle  out  N_KEYS  flips on every accepted press.

Behaviour:
- Interface: one clock, CLOCK_50. Reset RESET_N is asynchronous and active-low.
- Derived constants: DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS; HOLD_CYCLES = CLK_HZ/1000*HOLD_MS. Counter widths come from $clog2 of these. Counters saturate and never wrap.
- Reset (async assert, sync deassert handled upstream):
  - Every output is 0.
  - Both synchroniser flops load the "released" raw value (KEY_ACTIVE_LOW ? 1 : 0).
  - Each FSM goes to RELEASED; all counters are 0.
- Synchroniser: 2 flops per key, then polarity-normalised to s (1 = pressed).
- Per-key FSM, transitions on rising CLOCK_50:
  - RELEASED: s=1 -> DB_PRESS, db_cnt=0.
  - DB_PRESS:
    - s=0 -> RELEASED. This is a bounce; no output.
    - Otherwise db_cnt++.
    - When db_cnt==DB_CYCLES-1 and s=1 -> PRESSED: key_press=1 for one cycle, key_level=1, key_toggle inverts, hold_cnt=0, held=0.
  - PRESSED:
    - s=0 -> DB_RELEASE, db_cnt=0.
    - Otherwise hold_cnt++.
    - When hold_cnt==HOLD_CYCLES-1 -> HELD: key_hold pulse, held=1.
  - HELD: s=0 -> DB_RELEASE, db_cnt=0.
  - DB_RELEASE:
    - s=1 -> back to HELD if held, else PRESSED. This is a bounce; hold_cnt is frozen (not cleared) while in DB_RELEASE.
    - db_cnt==DB_CYCLES-1 and s=0 -> RELEASED: key_release pulse, key_level=0.
- Latency: if KEY changes before edge 0 and stays stable, key_press/key_release is high in the cycle after edge DB_CYCLES+2. That is DB_CYCLES+3 edges counting edge 0; the same figure is used in the Test Plan.
- key_hold fires exactly HOLD_CYCLES edges after key_press if the key is stably held.
- Pulses are registered, never combinational from KEY. key_press and key_release are never high in the same cycle for one key.
- Keys are fully independent. Simultaneous presses produce pulses in the same cycle.
- Reset mid-operation: in-flight debounce/hold is abandoned and toggles clear. A key still pressed after reset is re-detected as a fresh press after the normal latency.

Decomposition:
- Package key_reader_pkg:
  - key_state_t enum: RELEASED, DB_PRESS, PRESSED, HELD, DB_RELEASE.
  - Function ms_to_cycles(clk_hz, ms).
- Sub-module key_debounce_fsm: one key, containing the synchroniser, FSM, counters and toggle.
- key_reader instantiates N_KEYS of these in a generate loop.

Test Plan (bench uses CLK_HZ=1000, DEBOUNCE_MS=4 -> DB_CYCLES=4, HOLD_MS=20 -> HOLD_CYCLES=20, N_KEYS=4):
- Reset: KEY=4'b1111, RESET_N low 5 cycles then high 100 cycles -> all outputs 0 throughout.
- Clean press: KEY[0] 1->0 before edge 0, held 15 cycles -> key_press[0] high the cycle after edge 6 only; key_level[0]=1; key_toggle[0]=1; KEY[0] back to 1 -> key_release[0] 7 edges later; key_level[0]=0.
- Bounce reject: KEY[1] low 2, high 1, low 2, high -> no pulses, key_level[1] stays 0; toggle unchanged.
- Hold plus release bounce:
  - Stimulus: KEY[2] low 40 cycles with one 2-cycle high glitch at cycle 30.
  - Response: exactly one key_press; key_hold exactly 20 edges after key_press (before the glitch); no release pulse from the glitch.
  - Final release -> one key_release.
- Reset mid-debounce: KEY[3] low, assert RESET_N at cycle 2 of DB_PRESS -> outputs 0 immediately; deassert with KEY[3] still low -> key_press[3] 7 edges after the first post-reset edge.
- Simultaneous: KEY 1111->0000 at the same edge -> key_press=4'b1111 in one cycle; a second press cycle -> key_toggle returns to 4'b0000.
